// File: rtl/phase_lock_pkg.sv
// Shared types and helpers for the phase-lock loop controller: FSM state
// encoding, default width helpers and the frequency clamp decision.
package phase_lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    UPDATE
  } lock_state_t;

  typedef enum logic [1:0] {
    CLAMP_NONE,
    CLAMP_LO,
    CLAMP_HI
  } clamp_sel_t;

  localparam int DEF_POSITION_BITS = 14;
  localparam int DEF_AVG_LOG2      = 4;
  localparam int ACC_BITS          = DEF_POSITION_BITS + DEF_AVG_LOG2;
  localparam int ERR_BITS          = DEF_POSITION_BITS + 1;

  // Operands are pre-extended to 64 signed bits so any word width up to 62 bits fits.
  function automatic clamp_sel_t clamp_check(input logic signed [63:0] v,
                                             input logic signed [63:0] lo,
                                             input logic signed [63:0] hi);
    clamp_sel_t sel;
    sel = CLAMP_NONE;
    if (v < lo)      sel = CLAMP_LO;
    else if (v > hi) sel = CLAMP_HI;
    return sel;
  endfunction

endpackage

// File: rtl/phase_lock_ctrl_if.sv
// Control/data bundle between the loop controller and its surroundings
// (phase detector inputs, NCO frequency outputs, status).
interface phase_lock_ctrl_if #(
  parameter int POSITION_BITS = 14,
  parameter int FREQ_BITS     = 32
);
  logic                            CE;
  logic                            ENABLE;
  logic        [FREQ_BITS-1:0]     FREQ_INIT;
  logic        [FREQ_BITS-1:0]     FREQ_MIN;
  logic        [FREQ_BITS-1:0]     FREQ_MAX;
  logic signed [POSITION_BITS-1:0] PHASE_TARGET;
  logic signed [POSITION_BITS-1:0] PHASE_DIFFERENCE;
  logic        [FREQ_BITS-1:0]     FREQ_WORD;
  logic                            FREQ_UPDATE;
  logic signed [POSITION_BITS-1:0] AVG_PHASE;
  logic signed [POSITION_BITS:0]   PHASE_ERROR;
  logic                            LOCKED;
  logic                            BUSY;

  modport master (
    output CE, ENABLE, FREQ_INIT, FREQ_MIN, FREQ_MAX, PHASE_TARGET, PHASE_DIFFERENCE,
    input  FREQ_WORD, FREQ_UPDATE, AVG_PHASE, PHASE_ERROR, LOCKED, BUSY
  );

  modport slave (
    input  CE, ENABLE, FREQ_INIT, FREQ_MIN, FREQ_MAX, PHASE_TARGET, PHASE_DIFFERENCE,
    output FREQ_WORD, FREQ_UPDATE, AVG_PHASE, PHASE_ERROR, LOCKED, BUSY
  );
endinterface

// File: rtl/phase_avg_accum.sv
// Sample divider plus accumulator: takes one phase sample every SAMPLE_DIV
// enabled cycles and presents the floor average of 2^AVG_LOG2 samples.
module phase_avg_accum
  import phase_lock_pkg::*;
#(
  parameter int POSITION_BITS = 14,
  parameter int AVG_LOG2      = 4,
  parameter int SAMPLE_DIV    = 256
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ce,
  input  logic                            start,
  input  logic                            run,
  input  logic signed [POSITION_BITS-1:0] sample,
  output logic                            done,
  output logic signed [POSITION_BITS-1:0] avg
);
  localparam int ACC_W = POSITION_BITS + AVG_LOG2;
  localparam int DW    = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0]       DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

  logic        [DW-1:0]       div_cnt;
  logic        [AVG_LOG2-1:0] smp_cnt;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sample_ext;

  assign sample_ext = {{AVG_LOG2{sample[POSITION_BITS-1]}}, sample};
  // Dropping the low AVG_LOG2 bits is the arithmetic shift, already truncated to the input width.
  assign avg  = acc[ACC_W-1:AVG_LOG2];
  assign done = run && (div_cnt == DIV_LAST) && (smp_cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt <= '0;
      smp_cnt <= '0;
      acc     <= '0;
    end else if (ce) begin
      if (start) begin
        div_cnt <= '0;
        smp_cnt <= '0;
        acc     <= '0;
      end else if (run) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          smp_cnt <= smp_cnt + 1'b1;
          acc     <= acc + sample_ext;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phase_lock_ctrl.sv
// Integral phase-lock controller: averages detector phase, steers the NCO
// frequency word by the shifted error and tracks lock status.
module phase_lock_ctrl
  import phase_lock_pkg::*;
#(
  parameter int POSITION_BITS  = 14,
  parameter int FREQ_BITS      = 32,
  parameter int AVG_LOG2       = 4,
  parameter int SAMPLE_DIV     = 256,
  parameter int SETTLE_CYCLES  = 4096,
  parameter int K_SHIFT        = 6,
  parameter int LOCK_THRESHOLD = 8,
  parameter int LOCK_COUNT     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  phase_lock_ctrl_if.slave bus
);
  localparam int ERR_W = POSITION_BITS + 1;
  localparam int NXT_W = FREQ_BITS + 2;
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);
  localparam int LW    = $clog2(LOCK_COUNT + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0]    LOCK_FULL   = LW'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] LOCK_THR    = ERR_W'(LOCK_THRESHOLD);

  lock_state_t                     state;
  logic        [SW-1:0]            settle_cnt;
  logic        [LW-1:0]            lock_cnt;
  logic                            acc_start;
  logic                            acc_run;
  logic                            acc_done;
  logic signed [POSITION_BITS-1:0] avg;
  logic signed [ERR_W-1:0]         err_c;
  logic signed [ERR_W-1:0]         corr_c;
  logic        [ERR_W-1:0]         abs_err_c;
  logic signed [NXT_W-1:0]         next_c;
  logic        [FREQ_BITS-1:0]     freq_upd_c;
  logic        [FREQ_BITS-1:0]     freq_init_c;
  logic                            in_lock_c;

  function automatic logic [FREQ_BITS-1:0] sat_freq(input logic signed [NXT_W-1:0] v,
                                                    input logic [FREQ_BITS-1:0]    lo,
                                                    input logic [FREQ_BITS-1:0]    hi);
    logic signed [63:0]     v64;
    logic signed [63:0]     lo64;
    logic signed [63:0]     hi64;
    logic [FREQ_BITS-1:0]   r;
    v64  = {{(64-NXT_W){v[NXT_W-1]}}, v};
    lo64 = {{(64-FREQ_BITS){1'b0}}, lo};
    hi64 = {{(64-FREQ_BITS){1'b0}}, hi};
    case (clamp_check(v64, lo64, hi64))
      CLAMP_LO: r = lo;
      CLAMP_HI: r = hi;
      default:  r = v[FREQ_BITS-1:0];
    endcase
    return r;
  endfunction

  // Any drop of ENABLE discards the partial average; UPDATE re-arms the next window.
  assign acc_start = !bus.ENABLE || (state == UPDATE) ||
                     ((state == SETTLE) && (settle_cnt == SETTLE_LAST));
  assign acc_run   = bus.ENABLE && (state == MEASURE);

  phase_avg_accum #(
    .POSITION_BITS (POSITION_BITS),
    .AVG_LOG2      (AVG_LOG2),
    .SAMPLE_DIV    (SAMPLE_DIV)
  ) u_accum (
    .CLK    (CLK),
    .RESET  (RESET),
    .ce     (bus.CE),
    .start  (acc_start),
    .run    (acc_run),
    .sample (bus.PHASE_DIFFERENCE),
    .done   (acc_done),
    .avg    (avg)
  );

  always_comb begin
    err_c       = {avg[POSITION_BITS-1], avg} -
                  {bus.PHASE_TARGET[POSITION_BITS-1], bus.PHASE_TARGET};
    corr_c      = err_c >>> K_SHIFT;
    abs_err_c   = err_c[ERR_W-1] ? (~err_c + 1'b1) : err_c;
    in_lock_c   = (abs_err_c <= LOCK_THR);
    // Two guard bits keep the subtraction from wrapping before the clamp sees it.
    next_c      = $signed({2'b00, bus.FREQ_WORD}) -
                  {{(NXT_W-ERR_W){corr_c[ERR_W-1]}}, corr_c};
    freq_upd_c  = sat_freq(next_c, bus.FREQ_MIN, bus.FREQ_MAX);
    freq_init_c = sat_freq($signed({2'b00, bus.FREQ_INIT}), bus.FREQ_MIN, bus.FREQ_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      lock_cnt        <= '0;
      bus.FREQ_WORD   <= '0;
      bus.FREQ_UPDATE <= 1'b0;
      bus.AVG_PHASE   <= '0;
      bus.PHASE_ERROR <= '0;
      bus.LOCKED      <= 1'b0;
      bus.BUSY        <= 1'b0;
    end else if (!bus.CE) begin
      bus.FREQ_UPDATE <= 1'b0;
    end else begin
      bus.FREQ_UPDATE <= 1'b0;
      case (state)
        IDLE: begin
          bus.LOCKED <= 1'b0;
          if (bus.ENABLE) begin
            bus.FREQ_WORD   <= freq_init_c;
            bus.FREQ_UPDATE <= 1'b1;
            settle_cnt      <= '0;
            state           <= SETTLE;
            bus.BUSY        <= 1'b1;
          end
        end
        SETTLE: begin
          if (!bus.ENABLE) begin
            state      <= IDLE;
            bus.BUSY   <= 1'b0;
            bus.LOCKED <= 1'b0;
            lock_cnt   <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= MEASURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (!bus.ENABLE) begin
            state      <= IDLE;
            bus.BUSY   <= 1'b0;
            bus.LOCKED <= 1'b0;
            lock_cnt   <= '0;
          end else if (acc_done) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          bus.FREQ_WORD   <= freq_upd_c;
          bus.AVG_PHASE   <= avg;
          bus.PHASE_ERROR <= err_c;
          bus.FREQ_UPDATE <= 1'b1;
          if (in_lock_c) begin
            if (lock_cnt != LOCK_FULL) lock_cnt <= lock_cnt + 1'b1;
            bus.LOCKED <= (lock_cnt >= LOCK_FULL - 1'b1);
          end else begin
            lock_cnt   <= '0;
            bus.LOCKED <= 1'b0;
          end
          // A late ENABLE drop still lets this update land before idling.
          if (bus.ENABLE) begin
            state <= MEASURE;
          end else begin
            state      <= IDLE;
            bus.BUSY   <= 1'b0;
            bus.LOCKED <= 1'b0;
            lock_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_lock_ctrl.sv
// Directed bench for phase_lock_ctrl with short settle/divider settings so
// each loop update is easy to hand-compute.
module tb_phase_lock_ctrl;
  localparam int POSITION_BITS  = 14;
  localparam int FREQ_BITS      = 32;
  localparam int AVG_LOG2       = 2;
  localparam int SAMPLE_DIV     = 4;
  localparam int SETTLE_CYCLES  = 16;
  localparam int K_SHIFT        = 2;
  localparam int LOCK_THRESHOLD = 8;
  localparam int LOCK_COUNT     = 16;

  logic CLK;
  logic RESET;
  int   errors;
  int   checks;

  phase_lock_ctrl_if #(.POSITION_BITS(POSITION_BITS), .FREQ_BITS(FREQ_BITS)) bus ();

  phase_lock_ctrl #(
    .POSITION_BITS  (POSITION_BITS),
    .FREQ_BITS      (FREQ_BITS),
    .AVG_LOG2       (AVG_LOG2),
    .SAMPLE_DIV     (SAMPLE_DIV),
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .K_SHIFT        (K_SHIFT),
    .LOCK_THRESHOLD (LOCK_THRESHOLD),
    .LOCK_COUNT     (LOCK_COUNT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    bus.CE     = 1'b1;
    bus.ENABLE = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
  endtask

  task automatic start_loop(input logic [31:0] init);
    bus.FREQ_INIT = init;
    bus.ENABLE    = 1'b1;
    tick();
  endtask

  task automatic wait_update(input int max_cycles, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.FREQ_UPDATE !== 1'b1 && n < max_cycles);
  endtask

  task automatic set_loop(input logic [31:0] fmin, input logic [31:0] fmax,
                          input logic signed [13:0] tgt, input logic signed [13:0] diff);
    bus.FREQ_MIN         = fmin;
    bus.FREQ_MAX         = fmax;
    bus.PHASE_TARGET     = tgt;
    bus.PHASE_DIFFERENCE = diff;
  endtask

  task automatic test_reset();
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd36, 14'sd100);
    bus.FREQ_INIT = 32'h0100_0000;
    do_reset();
    checks++; if (bus.FREQ_WORD !== 32'd0) begin errors++; $display("FAIL reset_freq_word: got %0h want 0", bus.FREQ_WORD); end
    checks++; if (bus.FREQ_UPDATE !== 1'b0) begin errors++; $display("FAIL reset_freq_update: got %b want 0", bus.FREQ_UPDATE); end
    checks++; if (bus.AVG_PHASE !== 14'sd0) begin errors++; $display("FAIL reset_avg: got %0d want 0", bus.AVG_PHASE); end
    checks++; if (bus.PHASE_ERROR !== 15'sd0) begin errors++; $display("FAIL reset_err: got %0d want 0", bus.PHASE_ERROR); end
    checks++; if (bus.LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", bus.LOCKED); end
    tick();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
  endtask

  task automatic test_enable();
    start_loop(32'h0100_0000);
    checks++; if (bus.FREQ_WORD !== 32'h0100_0000) begin errors++; $display("FAIL enable_freq: got %0h want 1000000", bus.FREQ_WORD); end
    checks++; if (bus.FREQ_UPDATE !== 1'b1) begin errors++; $display("FAIL enable_pulse: got %b want 1", bus.FREQ_UPDATE); end
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL enable_busy: got %b want 1", bus.BUSY); end
  endtask

  task automatic test_latency();
    int n;
    wait_update(60, n);
    checks++; if (n != 33) begin errors++; $display("FAIL first_latency: got %0d want 33", n); end
    checks++; if (bus.AVG_PHASE !== 14'sd100) begin errors++; $display("FAIL lat_avg: got %0d want 100", bus.AVG_PHASE); end
    checks++; if (bus.PHASE_ERROR !== 15'sd64) begin errors++; $display("FAIL lat_err: got %0d want 64", bus.PHASE_ERROR); end
    checks++; if (bus.FREQ_WORD !== 32'h00FF_FFF0) begin errors++; $display("FAIL lat_freq: got %0h want fffff0", bus.FREQ_WORD); end
    tick();
    checks++; if (bus.FREQ_UPDATE !== 1'b0) begin errors++; $display("FAIL lat_pulse_width: got %b want 0", bus.FREQ_UPDATE); end
    wait_update(40, n);
    checks++; if (n != 16) begin errors++; $display("FAIL update_period: got %0d want 16", n); end
    checks++; if (bus.FREQ_WORD !== 32'h00FF_FFE0) begin errors++; $display("FAIL second_freq: got %0h want ffffe0", bus.FREQ_WORD); end
  endtask

  task automatic test_negative();
    int n;
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd0, -14'sd3);
    do_reset();
    start_loop(32'h0100_0000);
    wait_update(60, n);
    checks++; if (bus.AVG_PHASE !== -14'sd3) begin errors++; $display("FAIL neg_avg: got %0d want -3", bus.AVG_PHASE); end
    checks++; if (bus.PHASE_ERROR !== -15'sd3) begin errors++; $display("FAIL neg_err: got %0d want -3", bus.PHASE_ERROR); end
    checks++; if (bus.FREQ_WORD !== 32'h0100_0001) begin errors++; $display("FAIL neg_floor_freq: got %0h want 1000001", bus.FREQ_WORD); end
  endtask

  task automatic test_clamp();
    int n;
    set_loop(32'd1000, 32'hFFFF_FFFF, 14'sd0, 14'sd8000);
    do_reset();
    start_loop(32'd5);
    checks++; if (bus.FREQ_WORD !== 32'd1000) begin errors++; $display("FAIL init_clamp: got %0d want 1000", bus.FREQ_WORD); end
    wait_update(60, n);
    checks++; if (bus.FREQ_UPDATE !== 1'b1 || bus.FREQ_WORD !== 32'd1000) begin errors++; $display("FAIL clamp_min: got %0d want 1000", bus.FREQ_WORD); end
    checks++; if (bus.PHASE_ERROR !== 15'sd8000) begin errors++; $display("FAIL clamp_min_err: got %0d want 8000", bus.PHASE_ERROR); end
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd0, -14'sd8000);
    do_reset();
    start_loop(32'hFFFF_FFFF);
    wait_update(60, n);
    checks++; if (bus.FREQ_UPDATE !== 1'b1 || bus.FREQ_WORD !== 32'hFFFF_FFFF) begin errors++; $display("FAIL clamp_max: got %0h want ffffffff", bus.FREQ_WORD); end
    checks++; if (bus.PHASE_ERROR !== -15'sd8000) begin errors++; $display("FAIL clamp_max_err: got %0d want -8000", bus.PHASE_ERROR); end
  endtask

  task automatic test_lock();
    int n;
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd0, 14'sd5);
    do_reset();
    start_loop(32'h0100_0000);
    for (int i = 1; i <= LOCK_COUNT; i++) begin
      logic exp_lock;
      exp_lock = (i == LOCK_COUNT);
      wait_update(60, n);
      checks++;
      if (bus.FREQ_UPDATE !== 1'b1 || bus.LOCKED !== exp_lock) begin
        errors++; $display("FAIL lock_update_%0d: got upd=%b locked=%b want upd=1 locked=%b", i, bus.FREQ_UPDATE, bus.LOCKED, exp_lock);
      end
    end
    bus.PHASE_DIFFERENCE = 14'sd20;
    wait_update(60, n);
    checks++; if (bus.LOCKED !== 1'b0 || bus.PHASE_ERROR !== 15'sd20) begin errors++; $display("FAIL lock_break: got locked=%b err=%0d want 0/20", bus.LOCKED, bus.PHASE_ERROR); end
    bus.PHASE_DIFFERENCE = 14'sd5;
    wait_update(60, n);
    checks++; if (bus.FREQ_UPDATE !== 1'b1 || bus.LOCKED !== 1'b0) begin errors++; $display("FAIL lock_restart: got locked=%b want 0", bus.LOCKED); end
  endtask

  task automatic test_abort();
    int n;
    int pulses;
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd36, 14'sd100);
    do_reset();
    start_loop(32'h0100_0000);
    wait_update(60, n);
    repeat (5) tick();
    bus.ENABLE = 1'b0;
    tick();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.BUSY); end
    checks++; if (bus.FREQ_WORD !== 32'h00FF_FFF0 || bus.FREQ_UPDATE !== 1'b0) begin errors++; $display("FAIL abort_hold: got %0h upd=%b want fffff0 upd=0", bus.FREQ_WORD, bus.FREQ_UPDATE); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.FREQ_UPDATE === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_pulse: got %0d want 0", pulses); end
  endtask

  task automatic test_update_abort();
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd36, 14'sd100);
    do_reset();
    start_loop(32'h0100_0000);
    repeat (32) tick();
    bus.ENABLE = 1'b0;
    tick();
    checks++; if (bus.FREQ_UPDATE !== 1'b1 || bus.FREQ_WORD !== 32'h00FF_FFF0) begin errors++; $display("FAIL late_drop_update: got upd=%b freq=%0h want 1/fffff0", bus.FREQ_UPDATE, bus.FREQ_WORD); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL late_drop_busy: got %b want 0", bus.BUSY); end
  endtask

  task automatic test_ce_stall();
    int n;
    int pulses;
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd36, 14'sd100);
    do_reset();
    start_loop(32'h0100_0000);
    repeat (20) tick();
    bus.CE = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.FREQ_UPDATE === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL ce_freeze: got pulses=%0d busy=%b want 0/1", pulses, bus.BUSY); end
    bus.CE = 1'b1;
    wait_update(60, n);
    checks++; if (n != 13) begin errors++; $display("FAIL ce_shift: got %0d want 13", n); end
    checks++; if (bus.AVG_PHASE !== 14'sd100 || bus.PHASE_ERROR !== 15'sd64 || bus.FREQ_WORD !== 32'h00FF_FFF0) begin
      errors++; $display("FAIL ce_values: got avg=%0d err=%0d freq=%0h want 100/64/fffff0", bus.AVG_PHASE, bus.PHASE_ERROR, bus.FREQ_WORD);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RESET  = 1'b1;
    bus.CE = 1'b1;
    bus.ENABLE = 1'b0;
    bus.FREQ_INIT = '0;
    set_loop(32'd0, 32'hFFFF_FFFF, 14'sd0, 14'sd0);
    test_reset();
    test_enable();
    test_latency();
    test_negative();
    test_clamp();
    test_lock();
    test_abort();
    test_update_abort();
    test_ce_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
